// File: rtl/coder_pkg.sv
// Shared definitions for the round-robin arbiter and the downstream 8-to-3 coder:
// widths, arbiter state encoding, the one-hot grant type and a one-hot-to-index helper.
package coder_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT   = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

    typedef logic [N_REQ-1:0] onehot_t;

    // Valid only for a one-hot or all-zero input, which is all the arbiter ever produces.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input onehot_t oh);
        logic [IDX_W-1:0] idx;
        idx = {IDX_W{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-and-priority selector: returns the first set request
// scanning upward from ptr_i (modulo N_REQ) as a one-hot vector.
module rr_pick
    import coder_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output onehot_t          pick_o,
    output logic             valid_o
);

    // Scan from the pointer; the index width wraps the search naturally modulo 8.
    always_comb begin
        logic             found_s;
        logic [IDX_W-1:0] idx_s;
        onehot_t          pick_s;
        found_s = 1'b0;
        idx_s   = {IDX_W{1'b0}};
        pick_s  = {N_REQ{1'b0}};
        for (int k = 0; k < N_REQ; k++) begin
            idx_s = ptr_i + IDX_W'(k);
            if (!found_s && req_i[idx_s]) begin
                pick_s[idx_s] = 1'b1;
                found_s       = 1'b1;
            end else begin
                pick_s = pick_s;
            end
        end
        pick_o  = pick_s;
        valid_o = found_s;
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// 8-requester round-robin arbiter with registered one-hot grant (IDLE/GRANT/RELEASE).
// Optional owner hold limit of MAX_HOLD cycles is compiled in with RR_GRANT_TIMEOUT_EN.
module rr_grant_arbiter
    import coder_pkg::IDX_W, coder_pkg::IDLE, coder_pkg::GRANT, coder_pkg::RELEASE,
           coder_pkg::onehot_t, coder_pkg::onehot_to_idx;
#(
    parameter int N_REQ    = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic             busy,
    output logic [IDX_W-1:0] ptr
);

    logic [1:0]       state_q, state_d;
    onehot_t          grant_q, grant_d;
    logic             busy_q, busy_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    onehot_t          pick_s;
    logic             pick_valid_s;
    logic             owner_req_s;
    logic             timeout_hit_s;
    logic             hold_clr_s;
    logic [IDX_W-1:0] owner_idx_s;

    rr_pick u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .pick_o  (pick_s),
        .valid_o (pick_valid_s)
    );

    assign owner_req_s = |(req & grant_q);
    assign owner_idx_s = onehot_to_idx(grant_q);

`ifdef RR_GRANT_TIMEOUT_EN
    logic [7:0] hold_q, hold_d;

    assign timeout_hit_s = (hold_q == 8'(MAX_HOLD - 1));

    // Hold counter: cleared when a grant is issued, counts every cycle spent in GRANT.
    always_comb begin
        hold_d = hold_q;
        if (hold_clr_s) begin
            hold_d = 8'd0;
        end else if (state_q == GRANT) begin
            hold_d = hold_q + 8'd1;
        end else begin
            hold_d = hold_q;
        end
    end

    // Hold counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= 8'd0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    logic [7:0] unused_hold_s;

    assign unused_hold_s = 8'(MAX_HOLD);
    assign timeout_hit_s = 1'b0;
`endif

    // Next-state logic; the pointer moves only on release so grant issue never disturbs it.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        hold_clr_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid_s) begin
                    grant_d    = pick_s;
                    state_d    = GRANT;
                    hold_clr_s = 1'b1;
                end else begin
                    grant_d = {N_REQ{1'b0}};
                end
            end
            GRANT: begin
                if (!owner_req_s || timeout_hit_s) begin
                    grant_d = {N_REQ{1'b0}};
                    ptr_d   = owner_idx_s + IDX_W'(1);
                    state_d = RELEASE;
                end else begin
                    grant_d = grant_q;
                end
            end
            RELEASE: begin
                grant_d = {N_REQ{1'b0}};
                state_d = IDLE;
            end
            default: begin
                grant_d = {N_REQ{1'b0}};
                state_d = IDLE;
            end
        endcase
        busy_d = |grant_d;
    end

    // State and output registers; reset has priority over every other event.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= {N_REQ{1'b0}};
            busy_q  <= 1'b0;
            ptr_q   <= {IDX_W{1'b0}};
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant = grant_q;
    assign busy  = busy_q;
    assign ptr   = ptr_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Self-checking bench for rr_grant_arbiter: directed scenarios plus randomized
// requests against a cycle-level reference model of the round-robin rules.
module tb_rr_grant_arbiter;

    localparam int MAXH = 16;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] grant;
    logic       busy;
    logic [2:0] ptr;

    int checks   = 0;
    int failures = 0;

    // Reference model: phase 0 idle, 1 granted, 2 bubble
    int m_phase, m_owner, m_ptr, m_hold;

    rr_grant_arbiter #(.N_REQ(8), .MAX_HOLD(MAXH)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .grant (grant),
        .busy  (busy),
        .ptr   (ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_grant();
        logic [7:0] g;
        g = 8'h00;
        if (m_phase == 1) g[m_owner] = 1'b1;
        return g;
    endfunction

    function automatic int grant_index(input logic [7:0] g);
        int r;
        r = -1;
        for (int i = 0; i < 8; i++) if (g[i]) r = i;
        return r;
    endfunction

    task automatic model_step(input bit r, input logic [7:0] q);
        if (r) begin
            m_phase = 0; m_owner = 0; m_ptr = 0; m_hold = 0;
        end else if (m_phase == 0) begin
            for (int k = 7; k >= 0; k--) begin
                if (q[(m_ptr + k) % 8]) begin
                    m_owner = (m_ptr + k) % 8;
                    m_phase = 1;
                    m_hold  = 0;
                end
            end
        end else if (m_phase == 1) begin
            bit expire;
            expire = 1'b0;
`ifdef RR_GRANT_TIMEOUT_EN
            expire = (m_hold == MAXH - 1);
`endif
            if (!q[m_owner] || expire) begin
                m_phase = 2;
                m_ptr   = (m_owner + 1) % 8;
            end else begin
                m_hold++;
            end
        end else begin
            m_phase = 0;
        end
    endtask

    // One clock: apply inputs, advance model at the edge, compare on the falling edge.
    task automatic tick(input bit r, input logic [7:0] q);
        rst = r;
        req = q;
        @(posedge clk);
        model_step(r, q);
        @(negedge clk);
        chk("grant", {24'd0, grant}, {24'd0, m_grant()});
        chk("busy", {31'd0, busy}, {31'd0, m_phase == 1});
        chk("ptr", {29'd0, ptr}, m_ptr);
        chk("onehot0", {31'd0, $onehot0(grant)}, 32'd1);
    endtask

    initial begin
        int seq_n, held;
        logic [7:0] prev, nreq;
        rst = 1'b1;
        req = 8'h00;
        m_phase = 0; m_owner = 0; m_ptr = 0; m_hold = 0;
        @(negedge clk);

        // Reset with all requests high
        tick(1'b1, 8'hFF);
        tick(1'b1, 8'hFF);
        chk("rst_grant", {24'd0, grant}, 32'h00);
        chk("rst_ptr", {29'd0, ptr}, 32'd0);
        tick(1'b0, 8'hFF);
        chk("first_grant", {24'd0, grant}, 32'h01);

        // Priority and release bubble
        tick(1'b0, 8'h81);
        chk("prio_hold", {24'd0, grant}, 32'h01);
        tick(1'b0, 8'h80);
        chk("rel_grant0", {24'd0, grant}, 32'h00);
        chk("rel_ptr", {29'd0, ptr}, 32'd1);
        tick(1'b0, 8'h80);
        chk("rel_grant1", {24'd0, grant}, 32'h00);
        tick(1'b0, 8'h80);
        chk("prio_next", {24'd0, grant}, 32'h80);

        // Wrap from owner 7
        tick(1'b0, 8'h04);
        chk("wrap_ptr", {29'd0, ptr}, 32'd0);
        tick(1'b0, 8'h84);
        tick(1'b0, 8'h84);
        chk("wrap_grant", {24'd0, grant}, 32'h04);

        // Owner 3 holds; reset lands mid-grant
        tick(1'b0, 8'h08);
        tick(1'b0, 8'h08);
        tick(1'b0, 8'h08);
        chk("hold_start", {24'd0, grant}, 32'h08);
        for (int i = 0; i < 40; i++) begin
            tick(i == 20, 8'h08);
`ifndef RR_GRANT_TIMEOUT_EN
            if (i < 20) chk("hold_keep", {24'd0, grant}, 32'h08);
`endif
            if (i == 20) begin
                chk("midrst_grant", {24'd0, grant}, 32'h00);
                chk("midrst_ptr", {29'd0, ptr}, 32'd0);
            end
        end

`ifdef RR_GRANT_TIMEOUT_EN
        // Forced release after MAX_HOLD cycles
        tick(1'b1, 8'h00);
        for (int i = 0; i < MAXH; i++) begin
            tick(1'b0, 8'h18);
            chk("to_hold", {24'd0, grant}, 32'h08);
        end
        tick(1'b0, 8'h18);
        chk("to_bubble0", {24'd0, grant}, 32'h00);
        tick(1'b0, 8'h18);
        chk("to_bubble1", {24'd0, grant}, 32'h00);
        tick(1'b0, 8'h18);
        chk("to_next", {24'd0, grant}, 32'h10);
`endif

        // Chain: all requesting, each owner lets go after a few cycles
        tick(1'b1, 8'h00);
        seq_n = 0;
        held  = 0;
        prev  = 8'h00;
        for (int c = 0; c < 200 && seq_n < 9; c++) begin
            nreq = 8'hFF;
            if (m_phase == 1 && held == 3) nreq[m_owner] = 1'b0;
            tick(1'b0, nreq);
            if (grant != 8'h00 && prev == 8'h00) begin
                chk("chain_idx", grant_index(grant), seq_n % 8);
                seq_n++;
            end
            held = (m_phase == 1) ? held + 1 : 0;
            prev = grant;
        end
        chk("chain_count", seq_n, 32'd9);

        // Randomized traffic
        tick(1'b1, 8'h00);
        nreq = 8'h00;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) nreq = 8'($urandom);
            else if ($urandom_range(0, 3) == 0) nreq[$urandom_range(0, 7)] = ~nreq[$urandom_range(0, 7)];
            tick($urandom_range(0, 99) == 0, nreq);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
